// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Constants and types shared by the front-end blocks of the core.
//   XLEN_DEFAULT : default PC/address width
//   ILEN         : instruction width
//   NOP          : canonical RV32I no-op (addi x0, x0, 0), shown by the fetch
//                  unit while its queue is empty
//   opcode_e     : RV32I major opcodes
//   opcode_of()  : extracts the major opcode field of an instruction word
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN         = 32;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b000_0011,
    OPC_MISC_MEM = 7'b000_1111,
    OPC_OP_IMM   = 7'b001_0011,
    OPC_AUIPC    = 7'b001_0111,
    OPC_STORE    = 7'b010_0011,
    OPC_OP       = 7'b011_0011,
    OPC_LUI      = 7'b011_0111,
    OPC_BRANCH   = 7'b110_0011,
    OPC_JALR     = 7'b110_0111,
    OPC_JAL      = 7'b110_1111,
    OPC_SYSTEM   = 7'b111_0011
  } opcode_e;

  function automatic opcode_e opcode_of(input logic [ILEN-1:0] instr);
    return opcode_e'(instr[6:0]);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding {instruction, pc} pairs for the fetch unit.
// Read data is the current head (combinational from storage); a pushed word
// becomes visible the cycle after the push. Pointers carry one extra MSB so
// full and empty are told apart without a separate counter.
// Ports:
//   clk_i, rst_i : clock, synchronous active-low reset
//   flush        : drop all entries (wins over push and pop)
//   push, wdata  : write one entry (accepted when not full, or when popping)
//   pop          : advance the head (ignored when empty)
//   rdata        : head entry
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign empty = (wr_ptr == rd_ptr);
  // Same slot index with differing wrap bits: writer is one lap ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign pop_en  = pop & ~empty & ~flush;
  // A pop in the same cycle frees the head slot, so a full FIFO may still push.
  assign push_en = push & (~full | pop_en) & ~flush;

  assign rdata = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, whatever the order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; slots are only read after being
  // written, and leaving it unreset lets it map onto plain RAM/flop arrays.
  always_ff @(posedge clk_i) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Generates sequential PCs, issues in-order
// requests to an instruction memory of variable latency, buffers returned
// words with their PCs in a DEPTH-entry prefetch queue and hands them to the
// IF/ID register with a valid/ready handshake. A redirect flushes the queue,
// marks every still-outstanding request for discard and restarts fetching at
// the new target on the following cycle.
//
// Ports:
//   clk_i, rst_i          : clock, synchronous active-low reset
//   start_i               : fetch enable (in-flight requests still complete)
//   redirect_i            : flush and jump to redirect_pc_i
//   redirect_pc_i         : word-aligned redirect target
//   imem_req_o/addr_o     : request valid / address
//   imem_gnt_i            : request accepted this cycle
//   imem_rvalid_i/rdata_i : in-order response valid / instruction
//   instr_valid_o         : queue head valid
//   instr_o, pc_o         : head instruction and PC (NOP / 0 when empty)
//   instr_ready_i         : IF/ID accepts the head
//   perf_fetch_o          : saturating count of words pushed   (FETCH_PERF_EN)
//   perf_drop_o           : saturating count of discarded words (FETCH_PERF_EN)
//
// Build option: define FETCH_PERF_EN to add the two performance counters.
// -----------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [ILEN-1:0]  imem_rdata_i,
  output logic             instr_valid_o,
  output logic [ILEN-1:0]  instr_o,
  output logic [XLEN-1:0]  pc_o,
  input  logic             instr_ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_o,
  output logic [31:0]      perf_drop_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

  logic [XLEN-1:0]      req_pc;
  logic [XLEN-1:0]      resp_pc;
  logic [CW-1:0]        outst;
  logic [CW-1:0]        drop;
  logic [CW-1:0]        count;
  logic [CW-1:0]        outst_next;
  logic [CW:0]          credit_sum;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ILEN+XLEN-1:0] head;

  logic                 grant;
  logic                 dropping;
  logic                 push;
  logic                 pop;

  // ---------------------------------------------------------------------------
  // Issue. Credit counts words already queued plus words still in flight, from
  // registered state only, so the queue can never be overrun by returns.
  // Requests are masked while reset is held so a freshly reset memory never
  // sees one.
  // ---------------------------------------------------------------------------
  assign credit_sum  = {1'b0, count} + {1'b0, outst};
  assign imem_req_o  = rst_i & start_i & ~redirect_i & (credit_sum < DEPTH_LIM);
  assign imem_addr_o = req_pc;
  assign grant       = imem_req_o & imem_gnt_i;

  // ---------------------------------------------------------------------------
  // Response. A return is discarded when it belongs to a pre-redirect request
  // (drop != 0) or arrives in the redirect cycle itself.
  // ---------------------------------------------------------------------------
  assign dropping   = imem_rvalid_i & ((drop != '0) | redirect_i);
  assign pop        = ~fifo_empty & instr_ready_i;
  assign push       = imem_rvalid_i & ~dropping & (~fifo_full | pop);
  assign outst_next = outst + CW'(grant) - CW'(imem_rvalid_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      req_pc  <= RESET_PC;
      resp_pc <= RESET_PC;
      outst   <= '0;
      drop    <= '0;
    end else begin
      outst <= outst_next;
      if (redirect_i) begin
        req_pc  <= redirect_pc_i;
        resp_pc <= redirect_pc_i;
        // Everything still in flight after this cycle belongs to the old path.
        drop    <= outst_next;
      end else begin
        if (grant)                        req_pc  <= req_pc + XLEN'(4);
        if (push)                         resp_pc <= resp_pc + XLEN'(4);
        if (imem_rvalid_i && drop != '0)  drop    <= drop - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ILEN + XLEN)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (redirect_i),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_rdata_i, resp_pc}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // ---------------------------------------------------------------------------
  // Head presentation.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before any condition,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    instr_valid_o = ~fifo_empty;
    instr_o       = NOP;
    pc_o          = '0;
    if (!fifo_empty) begin
      instr_o = head[ILEN+XLEN-1:XLEN];
      pc_o    = head[XLEN-1:0];
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating event counters: words entering the queue and words discarded.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_fetch_o <= '0;
      perf_drop_o  <= '0;
    end else begin
      if (push && perf_fetch_o != 32'hFFFF_FFFF)    perf_fetch_o <= perf_fetch_o + 32'd1;
      if (dropping && perf_drop_o != 32'hFFFF_FFFF) perf_drop_o  <= perf_drop_o + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule
